unified_buffer_banked: RTL and testbench

//  On-chip scratchpad of the accelerator, organised as NUM_BANKS banks x BANK_DEPTH rows of signed words.
//  Two write ports: DMA fill from host memory, and writeback (WB) of results.
//  Two read ports: activation and weight, feeding the systolic array.
//  All ports operate concurrently in one clock domain.

---
 rtl/unified_buffer_banked.sv | 113 +++++++++++
 tb/tb_unified_buffer_banked.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/unified_buffer_banked.sv
`default_nettype none
// ============================================================================
//  Module      : unified_buffer_banked
//  Description : Banked on-chip scratchpad. Two write ports (DMA fill and
//                result writeback) and two registered read ports
//                (activation and weight), all concurrent in one clock domain.
//                Address MSBs select the bank, LSBs select the row.
//  Revision    : 1.0 - initial release
// ============================================================================
module unified_buffer_banked #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_BANKS  = 16,
    parameter int BANK_DEPTH = 16,
    localparam int BANK_BITS  = $clog2(NUM_BANKS),
    localparam int ROW_BITS   = $clog2(BANK_DEPTH),
    localparam int ADDR_WIDTH = BANK_BITS + ROW_BITS
) (
    input  logic                         CLK,
    input  logic                         SYNC_RST,
    input  logic                         EN,
    input  logic                         ActivationReadValid,
    input  logic                         WeightReadValid,
    input  logic                         DmaWriteValid,
    input  logic                         WbWriteValid,
    input  logic        [ADDR_WIDTH-1:0] ActivationReadAddress,
    input  logic        [ADDR_WIDTH-1:0] WeightReadAddress,
    input  logic        [ADDR_WIDTH-1:0] DmaWriteAddress,
    input  logic        [ADDR_WIDTH-1:0] WbWriteAddress,
    input  logic signed [DATA_WIDTH-1:0] DmaWriteData,
    input  logic signed [DATA_WIDTH-1:0] WbWriteData,
    output logic signed [DATA_WIDTH-1:0] ActivationReadData,
    output logic signed [DATA_WIDTH-1:0] WeightReadData
);

    // Storage: one flop row set per bank
    logic signed [DATA_WIDTH-1:0] r_mem [NUM_BANKS][BANK_DEPTH];

    logic signed [DATA_WIDTH-1:0] r_actData;
    logic signed [DATA_WIDTH-1:0] r_wgtData;

    // Address decode (bank = MSBs, row = LSBs)
    logic [BANK_BITS-1:0] w_dmaBank;
    logic [BANK_BITS-1:0] w_wbBank;
    logic [BANK_BITS-1:0] w_actBank;
    logic [BANK_BITS-1:0] w_wgtBank;
    logic [ROW_BITS-1:0]  w_dmaRow;
    logic [ROW_BITS-1:0]  w_wbRow;
    logic [ROW_BITS-1:0]  w_actRow;
    logic [ROW_BITS-1:0]  w_wgtRow;

    assign w_dmaBank = DmaWriteAddress[ADDR_WIDTH-1 -: BANK_BITS];
    assign w_wbBank  = WbWriteAddress[ADDR_WIDTH-1 -: BANK_BITS];
    assign w_actBank = ActivationReadAddress[ADDR_WIDTH-1 -: BANK_BITS];
    assign w_wgtBank = WeightReadAddress[ADDR_WIDTH-1 -: BANK_BITS];
    assign w_dmaRow  = DmaWriteAddress[ROW_BITS-1:0];
    assign w_wbRow   = WbWriteAddress[ROW_BITS-1:0];
    assign w_actRow  = ActivationReadAddress[ROW_BITS-1:0];
    assign w_wgtRow  = WeightReadAddress[ROW_BITS-1:0];

    // Qualified write strobes: a write only happens with EN high
    logic w_dmaWr;
    logic w_wbWr;

    assign w_dmaWr = EN && DmaWriteValid;
    assign w_wbWr  = EN && WbWriteValid;

    genvar gb;
    generate
        for (gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
            logic w_dmaHit;
            logic w_wbHit;

            assign w_dmaHit = w_dmaWr && (w_dmaBank == BANK_BITS'(gb));
            assign w_wbHit  = w_wbWr  && (w_wbBank  == BANK_BITS'(gb));

            // Bank write: DMA is applied last so it wins on an identical address
            always_ff @(posedge CLK) begin
                if (SYNC_RST) begin
                    for (int r = 0; r < BANK_DEPTH; r++) begin
                        r_mem[gb][r] <= '0;
                    end
                end else begin
                    if (w_wbHit) begin
                        r_mem[gb][w_wbRow] <= WbWriteData;
                    end
                    if (w_dmaHit) begin
                        r_mem[gb][w_dmaRow] <= DmaWriteData;
                    end
                end
            end
        end
    endgenerate

    // Read registers: sample pre-edge contents, so same-cycle writes read old data
    always_ff @(posedge CLK) begin
        if (SYNC_RST) begin
            r_actData <= '0;
            r_wgtData <= '0;
        end else if (EN) begin
            if (ActivationReadValid) begin
                r_actData <= r_mem[w_actBank][w_actRow];
            end
            if (WeightReadValid) begin
                r_wgtData <= r_mem[w_wgtBank][w_wgtRow];
            end
        end
    end

    assign ActivationReadData = r_actData;
    assign WeightReadData     = r_wgtData;

endmodule
`default_nettype wire

// File: tb/tb_unified_buffer_banked.sv
`default_nettype none
// ============================================================================
//  Module      : tb_unified_buffer_banked
//  Description : Directed self-checking bench for unified_buffer_banked.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_unified_buffer_banked;

    logic              CLK = 1'b0;
    logic              SYNC_RST;
    logic              EN;
    logic              ActivationReadValid;
    logic              WeightReadValid;
    logic              DmaWriteValid;
    logic              WbWriteValid;
    logic        [7:0] ActivationReadAddress;
    logic        [7:0] WeightReadAddress;
    logic        [7:0] DmaWriteAddress;
    logic        [7:0] WbWriteAddress;
    logic signed [7:0] DmaWriteData;
    logic signed [7:0] WbWriteData;
    logic signed [7:0] ActivationReadData;
    logic signed [7:0] WeightReadData;

    int passCount = 0;
    int totalCount = 0;

    unified_buffer_banked dut (
        .CLK                   (CLK),
        .SYNC_RST              (SYNC_RST),
        .EN                    (EN),
        .ActivationReadValid   (ActivationReadValid),
        .WeightReadValid       (WeightReadValid),
        .DmaWriteValid         (DmaWriteValid),
        .WbWriteValid          (WbWriteValid),
        .ActivationReadAddress (ActivationReadAddress),
        .WeightReadAddress     (WeightReadAddress),
        .DmaWriteAddress       (DmaWriteAddress),
        .WbWriteAddress        (WbWriteAddress),
        .DmaWriteData          (DmaWriteData),
        .WbWriteData           (WbWriteData),
        .ActivationReadData    (ActivationReadData),
        .WeightReadData        (WeightReadData)
    );

    always #5 CLK = ~CLK;

    // One rising edge, then settle before sampling outputs
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [7:0] obs,
                         input logic signed [7:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic readBoth(input logic [7:0] actAddr, input logic [7:0] wgtAddr);
        ActivationReadValid   = 1'b1;
        WeightReadValid       = 1'b1;
        ActivationReadAddress = actAddr;
        WeightReadAddress     = wgtAddr;
    endtask

    initial begin
        SYNC_RST = 1'b1; EN = 1'b1;
        ActivationReadValid = 1'b0; WeightReadValid = 1'b0;
        DmaWriteValid = 1'b0; WbWriteValid = 1'b0;
        ActivationReadAddress = '0; WeightReadAddress = '0;
        DmaWriteAddress = '0; WbWriteAddress = '0;
        DmaWriteData = '0; WbWriteData = '0;

        // 1. reset pulse, then read 8'h25 on both ports
        step();
        SYNC_RST = 1'b0;
        check("rst_act", ActivationReadData, 8'sd0);
        check("rst_wgt", WeightReadData, 8'sd0);
        readBoth(8'h25, 8'h25);
        step();
        check("t1_act_25", ActivationReadData, 8'sd0);
        check("t1_wgt_25", WeightReadData, 8'sd0);
        ActivationReadValid = 1'b0; WeightReadValid = 1'b0;

        // 2. per-port writes then reads
        DmaWriteValid = 1'b1; DmaWriteAddress = 8'h25; DmaWriteData = 8'sd120;
        step();
        DmaWriteValid = 1'b0;
        WbWriteValid = 1'b1; WbWriteAddress = 8'h93; WbWriteData = 8'sd101;
        step();
        WbWriteValid = 1'b0;
        readBoth(8'h25, 8'h93);
        step();
        check("t2_act_25", ActivationReadData, 8'sd120);
        check("t2_wgt_93", WeightReadData, 8'sd101);
        // invalid reads hold previous output
        ActivationReadValid = 1'b0; WeightReadValid = 1'b0;
        ActivationReadAddress = 8'h23; WeightReadAddress = 8'h23;
        step();
        check("t2_act_hold", ActivationReadData, 8'sd120);
        check("t2_wgt_hold", WeightReadData, 8'sd101);

        // 3. concurrent DMA + WB over two cycles
        DmaWriteValid = 1'b1; DmaWriteAddress = 8'h23; DmaWriteData = 8'sd120;
        WbWriteValid  = 1'b1; WbWriteAddress  = 8'hA3; WbWriteData  = 8'sd95;
        step();
        DmaWriteAddress = 8'h24; DmaWriteData = 8'sd120;
        WbWriteAddress  = 8'h13; WbWriteData  = 8'sd101;
        step();
        DmaWriteValid = 1'b0; WbWriteValid = 1'b0;
        readBoth(8'hA3, 8'h23);
        step();
        check("t3_act_A3", ActivationReadData, 8'sd95);
        check("t3_wgt_23", WeightReadData, 8'sd120);
        readBoth(8'h24, 8'h13);
        step();
        check("t3_act_24", ActivationReadData, 8'sd120);
        check("t3_wgt_13", WeightReadData, 8'sd101);
        ActivationReadValid = 1'b0; WeightReadValid = 1'b0;

        // 4. same-address collision: DMA wins
        DmaWriteValid = 1'b1; DmaWriteAddress = 8'h44; DmaWriteData = 8'sd7;
        WbWriteValid  = 1'b1; WbWriteAddress  = 8'h44; WbWriteData  = -8'sd3;
        step();
        DmaWriteValid = 1'b0; WbWriteValid = 1'b0;
        readBoth(8'h44, 8'h13);
        step();
        check("t4_collide_44", ActivationReadData, 8'sd7);
        // read-during-write returns old contents
        readBoth(8'h44, 8'h44);
        DmaWriteValid = 1'b1; DmaWriteAddress = 8'h44; DmaWriteData = 8'sd9;
        step();
        DmaWriteValid = 1'b0;
        check("t4_rdw_act_old", ActivationReadData, 8'sd7);
        check("t4_rdw_wgt_old", WeightReadData, 8'sd7);
        step();
        check("t4_act_new", ActivationReadData, 8'sd9);
        check("t4_wgt_new", WeightReadData, 8'sd9);

        // 5. EN=0 freezes everything for two cycles
        EN = 1'b0;
        DmaWriteValid = 1'b1; DmaWriteAddress = 8'h25; DmaWriteData = -8'sd1;
        readBoth(8'h25, 8'h93);
        step();
        check("t5_en0_act_c1", ActivationReadData, 8'sd9);
        check("t5_en0_wgt_c1", WeightReadData, 8'sd9);
        step();
        check("t5_en0_act_c2", ActivationReadData, 8'sd9);
        check("t5_en0_wgt_c2", WeightReadData, 8'sd9);
        EN = 1'b1;
        DmaWriteValid = 1'b0;
        step();
        check("t5_act_25", ActivationReadData, 8'sd120);
        check("t5_wgt_93", WeightReadData, 8'sd101);

        // 6. reset during a WB write discards it and clears memory
        SYNC_RST = 1'b1;
        WbWriteValid = 1'b1; WbWriteAddress = 8'h93; WbWriteData = 8'sd55;
        readBoth(8'h25, 8'h93);
        step();
        SYNC_RST = 1'b0;
        WbWriteValid = 1'b0;
        check("t6_rst_act", ActivationReadData, 8'sd0);
        check("t6_rst_wgt", WeightReadData, 8'sd0);
        readBoth(8'h93, 8'hA3);
        step();
        check("t6_act_93", ActivationReadData, 8'sd0);
        check("t6_wgt_A3", WeightReadData, 8'sd0);
        readBoth(8'h25, 8'h13);
        step();
        check("t6_act_25", ActivationReadData, 8'sd0);
        check("t6_wgt_13", WeightReadData, 8'sd0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
`default_nettype wire
